// File: rtl/match_sequencer_if.sv
// Game-flow bus between the match sequencer and its neighbours.
//
// Carries the menu/input-bridge controls into the sequencer and the
// ball strobes, scores and renderer flags out of it.
//   master : the match sequencer itself (drives flags, strobes, scores)
//   slave  : the surrounding logic (drives start/mode/point pulses)
//
// Signals:
//   start_trigger  one-cycle start/confirm pulse
//   mode_choice    menu selection, 2'b11 invalid
//   point_p1       one-cycle pulse: ball passed the P2 (right) goal
//   point_p2       one-cycle pulse: ball passed the P1 (left) goal
//   game_startup   high in MENU
//   play_active    high in PLAY
//   sq_shown       ball visible
//   ball_reset     one-cycle recentre strobe
//   ball_release   one-cycle launch strobe
//   serve_dir      0 = toward P2/right, 1 = toward P1/left
//   score_p1/2     4-bit scores
//   game_over      high in OVER
//   mode_latched   mode_choice captured at match start
interface match_sequencer_if;
  logic       start_trigger;
  logic [1:0] mode_choice;
  logic       point_p1;
  logic       point_p2;
  logic       game_startup;
  logic       play_active;
  logic       sq_shown;
  logic       ball_reset;
  logic       ball_release;
  logic       serve_dir;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic [1:0] mode_latched;

  modport master (
    input  start_trigger, mode_choice, point_p1, point_p2,
    output game_startup, play_active, sq_shown, ball_reset, ball_release,
           serve_dir, score_p1, score_p2, game_over, mode_latched
  );

  modport slave (
    output start_trigger, mode_choice, point_p1, point_p2,
    input  game_startup, play_active, sq_shown, ball_reset, ball_release,
           serve_dir, score_p1, score_p2, game_over, mode_latched
  );
endinterface

// File: rtl/match_sequencer.sv
// Pong match sequencer: MENU -> SERVE countdown -> PLAY -> SCORED pause,
// ending in OVER once a player reaches WIN_SCORE. Owns both scores and
// the serve direction, issues the ball recentre/release strobes and the
// renderer visibility/status flags. All outputs are registered.
//
// Ports:
//   clk_0  pixel clock, rising edge
//   rst    asynchronous, active-high reset
//   seq    game-flow bus (master side), see match_sequencer_if
//
// Parameters:
//   CLK_HZ          clock frequency; CYC_PER_MS = CLK_HZ/1000 (truncated)
//   SERVE_DELAY_MS  countdown before ball release (>= 1)
//   BLINK_MS        ball blink half-period in the countdown (>= 1)
//   POINT_PAUSE_MS  blank pause after a point (>= 1)
//   WIN_SCORE       score ending the match (1..15)
module match_sequencer #(
  parameter int unsigned CLK_HZ         = 25_175_000,
  parameter int unsigned SERVE_DELAY_MS = 1000,
  parameter int unsigned BLINK_MS       = 250,
  parameter int unsigned POINT_PAUSE_MS = 500,
  parameter int unsigned WIN_SCORE      = 7
) (
  input  logic              clk_0,
  input  logic              rst,
  match_sequencer_if.master seq
);

  localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
  localparam int unsigned PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CYC_PER_MS - 1);
  localparam logic [15:0]      SERVE_LAST = 16'(SERVE_DELAY_MS - 1);
  localparam logic [15:0]      BLINK_LAST = 16'(BLINK_MS - 1);
  localparam logic [15:0]      PAUSE_LAST = 16'(POINT_PAUSE_MS - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    MENU,
    SERVE,
    PLAY,
    SCORED,
    OVER
  } state_t;

  state_t state;

  // Delay timer: prescaler divides to 1 ms, ms_cnt counts elapsed ms,
  // blink_cnt counts ms within the current blink half-period.
  logic [PRE_W-1:0] pre_cnt;
  logic [15:0]      ms_cnt;
  logic [15:0]      blink_cnt;
  logic [15:0]      delay_last;
  logic             timer_run;
  logic             ms_tick;
  logic             expire;
  logic             blink_tick;

  logic       game_startup_q;
  logic       play_active_q;
  logic       sq_shown_q;
  logic       ball_reset_q;
  logic       ball_release_q;
  logic       serve_dir_q;
  logic [3:0] score_p1_q;
  logic [3:0] score_p2_q;
  logic       game_over_q;
  logic [1:0] mode_latched_q;

  logic [3:0] score_p1_inc;
  logic [3:0] score_p2_inc;

  assign score_p1_inc = score_p1_q + 4'd1;
  assign score_p2_inc = score_p2_q + 4'd1;

  // Only SERVE and SCORED are timed; everywhere else the timer is held at
  // zero, so any entry into a timed state starts from a cleared count.
  always_comb begin
    timer_run  = 1'b0;
    delay_last = '0;
    unique case (state)
      SERVE: begin
        timer_run  = 1'b1;
        delay_last = SERVE_LAST;
      end
      SCORED: begin
        timer_run  = 1'b1;
        delay_last = PAUSE_LAST;
      end
      default: ;
    endcase
  end

  assign ms_tick    = (pre_cnt == PRE_LAST);
  // Fires on the edge that completes N*CYC_PER_MS cycles since entry.
  assign expire     = timer_run && ms_tick && (ms_cnt == delay_last);
  assign blink_tick = (state == SERVE) && ms_tick && (blink_cnt == BLINK_LAST);

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      ms_cnt    <= '0;
      blink_cnt <= '0;
    end else if (!timer_run || expire) begin
      pre_cnt   <= '0;
      ms_cnt    <= '0;
      blink_cnt <= '0;
    end else begin
      if (ms_tick) begin
        pre_cnt <= '0;
        ms_cnt  <= ms_cnt + 16'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      if (blink_tick) begin
        blink_cnt <= '0;
      end else if (ms_tick && state == SERVE) begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state          <= MENU;
      game_startup_q <= 1'b1;
      play_active_q  <= 1'b0;
      sq_shown_q     <= 1'b0;
      ball_reset_q   <= 1'b0;
      ball_release_q <= 1'b0;
      serve_dir_q    <= 1'b0;
      score_p1_q     <= '0;
      score_p2_q     <= '0;
      game_over_q    <= 1'b0;
      mode_latched_q <= '0;
    end else begin
      ball_reset_q   <= 1'b0;
      ball_release_q <= 1'b0;

      unique case (state)
        MENU: begin
          if (seq.start_trigger && seq.mode_choice != 2'b11) begin
            state          <= SERVE;
            mode_latched_q <= seq.mode_choice;
            score_p1_q     <= '0;
            score_p2_q     <= '0;
            serve_dir_q    <= 1'b0;
            game_startup_q <= 1'b0;
            ball_reset_q   <= 1'b1;
            sq_shown_q     <= 1'b1;
          end
        end

        SERVE: begin
          if (blink_tick) begin
            sq_shown_q <= ~sq_shown_q;
          end
          // The release edge overrides a coinciding blink toggle.
          if (expire) begin
            state          <= PLAY;
            ball_release_q <= 1'b1;
            sq_shown_q     <= 1'b1;
            play_active_q  <= 1'b1;
          end
        end

        PLAY: begin
          if (seq.point_p1 && seq.point_p2) begin
            // Void rally: replay the point without scoring.
            state         <= SCORED;
            play_active_q <= 1'b0;
            sq_shown_q    <= 1'b0;
          end else if (seq.point_p1) begin
            score_p1_q    <= score_p1_inc;
            serve_dir_q   <= 1'b0;
            play_active_q <= 1'b0;
            sq_shown_q    <= 1'b0;
            if (score_p1_inc == WIN) begin
              state       <= OVER;
              game_over_q <= 1'b1;
            end else begin
              state <= SCORED;
            end
          end else if (seq.point_p2) begin
            score_p2_q    <= score_p2_inc;
            serve_dir_q   <= 1'b1;
            play_active_q <= 1'b0;
            sq_shown_q    <= 1'b0;
            if (score_p2_inc == WIN) begin
              state       <= OVER;
              game_over_q <= 1'b1;
            end else begin
              state <= SCORED;
            end
          end
        end

        SCORED: begin
          if (expire) begin
            state        <= SERVE;
            ball_reset_q <= 1'b1;
            sq_shown_q   <= 1'b1;
          end
        end

        OVER: begin
          if (seq.start_trigger) begin
            state          <= MENU;
            score_p1_q     <= '0;
            score_p2_q     <= '0;
            game_over_q    <= 1'b0;
            game_startup_q <= 1'b1;
          end
        end

        default: state <= MENU;
      endcase
    end
  end

  assign seq.game_startup = game_startup_q;
  assign seq.play_active  = play_active_q;
  assign seq.sq_shown     = sq_shown_q;
  assign seq.ball_reset   = ball_reset_q;
  assign seq.ball_release = ball_release_q;
  assign seq.serve_dir    = serve_dir_q;
  assign seq.score_p1     = score_p1_q;
  assign seq.score_p2     = score_p2_q;
  assign seq.game_over    = game_over_q;
  assign seq.mode_latched = mode_latched_q;

endmodule
